llr_frame_scheduler: RTL and testbench
======================================

// Module: llr_frame_scheduler
// PURPOSE
//  Frame sequencer in front of the LLR decoder output stage. Collects input samples into a
//  two-bank ping-pong buffer, DEPTH_BUF words per bank, using a per-frame length (blklen).
//  Streams each complete frame out on m_axis_llr with start-of-frame (SOF) and end-of-frame
//  (EOF) framing. Bank ownership passes between the write side and the read side, so input
//  and output overlap.
// PARAMETERS
//  DATA_WIDTH  16   sample width and blklen width
//  DEPTH_BUF   256  words per bank (max frame length); power of 2; AW=$clog2(DEPTH_BUF)+1 localparam
// PORTS
//  aclk               in   1           clock; all logic on rising edge
//  aresetn            in   1           asynchronous active-low reset
//  blklen             in   DATA_WIDTH  frame length; sampled on the first beat of each frame
//  s_axis_in_tdata    in   DATA_WIDTH  input sample
//  s_axis_in_tvalid   in   1           input valid
//  s_axis_in_tready   out  1           input ready
//  s_axis_in_tlast    in   1           upstream end-of-frame (used only with TLAST_CHECK_EN)
//  m_axis_llr_tdata   out  DATA_WIDTH  output sample
//  m_axis_llr_tvalid  out  1           output valid
//  m_axis_llr_tready  in   1           output ready
//  m_axis_llr_tuser   out  1           SOF; high on beat 0 of a frame
//  m_axis_llr_tlast   out  1           EOF; high on the last beat of a frame
//  bank_full          out  2           per-bank "holds a complete frame" flag
//  frm_err            out  1           1-cycle pulse on a length/config error
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; wr_bank=rd_bank=0; both banks empty; FSMs idle.
//  Transfer: a beat moves when valid&ready are both high. Valid never depends on ready.
//    tdata/tuser/tlast are held stable while tvalid=1 and tready=0.
//  Write FSM
//    W_IDLE: tready = ~bank_full[wr_bank].
//      First accepted beat: latch len = blklen; write word 0; go to W_FILL.
//      Frame with len==1: completes immediately.
//    W_FILL: write at wcnt; wcnt++.
//      Beat with wcnt==len-1: set bank_full[wr_bank]; store len for that bank; toggle wr_bank; go to W_IDLE.
//  Length rule: blklen==0 or blklen>DEPTH_BUF -> len=DEPTH_BUF, with a frm_err pulse on the latching cycle.
//  Read FSM
//    R_IDLE: when bank_full[rd_bank]=1, go to R_RUN.
//    R_RUN:
//      - RAM read latency is 1 cycle; a 1-entry output register plus a 1-entry skid stage
//        sustain 1 beat/clk under continuous tready.
//      - First m_axis_llr_tvalid rises 2 cycles after bank_full[rd_bank] sets.
//      - tuser=1 when rcnt==0; tlast=1 when rcnt==len-1.
//      - On the tlast handshake: clear bank_full[rd_bank]; toggle rd_bank; go to R_IDLE.
//        With the next bank already full, the next frame follows back-to-back with no bubble.
//  Boundaries:
//    - Both banks full: s_axis_in_tready=0 until the reader frees one.
//    - Set and clear on different banks in the same cycle: both take effect.
//    - The set of bank X and the clear of bank X can never coincide; the bench asserts this.
//    - Reset mid-frame: partial frames are discarded; no EOF is emitted.
// CONFIGURATION
//  TLAST_CHECK_EN defined:
//    - s_axis_in_tlast on beat wcnt<len-1 ends the frame early: len=wcnt+1, bank committed, frm_err pulses.
//    - Missing tlast on beat len-1: frame still ends by count, frm_err pulses.
//  TLAST_CHECK_EN undefined: s_axis_in_tlast is ignored; frames end by count only; frm_err is blklen errors only.
// STRUCTURE
//  llr_sched_pkg: wr_state_e {W_IDLE,W_FILL}, rd_state_e {R_IDLE,R_RUN}, bank_t (1-bit index),
//    function clamp_len().
//  Sub-module llr_pingpong_ram: simple dual-port RAM of 2*DEPTH_BUF x DATA_WIDTH,
//    address {bank,idx}, synchronous read, 1-cycle latency. The scheduler holds the FSMs,
//    counters, flags and output skid register.
// TESTING
//  1 blklen=8, 8 beats 1..8, tready=1 -> out 1..8; tuser on beat 1, tlast on beat 8; first valid 2 clk after bank_full[0].
//  2 blklen=4, 3 frames back-to-back, tready=0 -> tready drops after 8 beats, bank_full=2'b11;
//    raise tready -> 12 beats, no bubble between frames.
//  3 blklen=0, then 300 beats, DEPTH_BUF=256 -> frm_err pulse; frame of 256 beats; tlast on beat 256.
//  4 Random tready 50% on blklen=16 -> data order preserved; tdata stable while stalled.
//  5 TLAST_CHECK_EN: blklen=10, tlast on beat 6 -> frm_err; output frame of 6 beats, tlast on beat 6.
//    Without the macro: 10 beats.
//  6 aresetn low mid-output (beat 3 of 8) -> outputs 0 immediately; after release,
//    new blklen=2 frame gives exactly 2 beats with SOF/EOF.

Source files
------------

// File: rtl/llr_sched_pkg.sv
// llr_sched_pkg: FSM state types, bank index type and frame-length clamp for llr_frame_scheduler
package llr_sched_pkg;
  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_RUN} rd_state_e;
  typedef logic bank_t;
  function automatic int unsigned clamp_len(input int unsigned blk, input int unsigned depth);
    return (blk == 0 || blk > depth) ? depth : blk;
  endfunction
endpackage

// File: rtl/llr_pingpong_ram.sv
// llr_pingpong_ram: two-bank simple dual-port RAM addressed as {bank, idx}, registered read
module llr_pingpong_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 9
) (
  input  logic                  aclk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**AW];
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/llr_frame_scheduler.sv
// llr_frame_scheduler: ping-pong frame buffer feeding the LLR output stream with SOF/EOF framing.
// Define TLAST_CHECK_EN to let upstream tlast end frames early and flag a missing tlast on frm_err.
module llr_frame_scheduler
  import llr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_BUF  = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] blklen,
  input  logic [DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  output logic                  s_axis_in_tready,
  input  logic                  s_axis_in_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_llr_tdata,
  output logic                  m_axis_llr_tvalid,
  input  logic                  m_axis_llr_tready,
  output logic                  m_axis_llr_tuser,
  output logic                  m_axis_llr_tlast,
  output logic [1:0]            bank_full,
  output logic                  frm_err
);
  localparam int AW = $clog2(DEPTH_BUF) + 1;
  localparam int EW = DATA_WIDTH + 2;
  logic [1:0] rst_q;
  logic rst_ni;
  wr_state_e wr_st, wr_nx;
  rd_state_e rd_st, rd_nx;
  bank_t wr_bank, rd_bank, ib;
  logic [AW-1:0] wcnt, wcnt_nx, len_q, len_nx, len_c, cur_idx, cur_len, icnt, ilen;
  logic [AW-1:0] bank_len [2];
  logic s_fire, len_err, by_cnt, done, err;
  logic [1:0] bf_set, bf_clr, iss_done, iss_set;
  logic issue, i_last, pop, o_fire_last;
  logic o_v, s_v, p_v, p_user, p_last;
  logic [EW-1:0] o_q, s_q, p_ent;
  logic [DATA_WIDTH-1:0] q;
  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_ni = rst_q[1];
  assign s_axis_in_tready = rst_ni & ~bank_full[wr_bank];
  assign s_fire  = s_axis_in_tvalid & s_axis_in_tready;
  assign len_err = blklen == '0 || 32'(blklen) > 32'(DEPTH_BUF);
  assign len_c   = AW'(clamp_len(32'(blklen), DEPTH_BUF));
  assign cur_idx = wr_st == W_IDLE ? '0 : wcnt;
  assign cur_len = wr_st == W_IDLE ? len_c : len_q;
  assign by_cnt  = cur_idx == cur_len - 1'b1;
`ifdef TLAST_CHECK_EN
  assign done = by_cnt | s_axis_in_tlast;
  assign err  = s_fire & ((wr_st == W_IDLE & len_err) | (by_cnt ^ s_axis_in_tlast));
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_in_tlast;
  assign done = by_cnt;
  assign err  = s_fire & (wr_st == W_IDLE) & len_err;
`endif
  assign bf_set = {2{s_fire & done}} & (wr_bank ? 2'b10 : 2'b01);
  always_comb begin
    wr_nx   = wr_st;
    wcnt_nx = wcnt;
    len_nx  = len_q;
    if (s_fire) begin
      wr_nx   = done ? W_IDLE : W_FILL;
      wcnt_nx = done ? '0 : cur_idx + 1'b1;
      len_nx  = cur_len;
    end
  end
  always_ff @(posedge aclk or negedge rst_ni)
    if (!rst_ni) begin
      wr_st    <= W_IDLE;
      wcnt     <= '0;
      len_q    <= '0;
      wr_bank  <= 1'b0;
      bank_len <= '{default: '0};
      frm_err  <= 1'b0;
    end else begin
      wr_st   <= wr_nx;
      wcnt    <= wcnt_nx;
      len_q   <= len_nx;
      frm_err <= err;
      if (s_fire & done) begin
        bank_len[wr_bank] <= cur_idx + 1'b1;
        wr_bank           <= ~wr_bank;
      end
    end
  // Reads are issued from bank ib ahead of rd_bank so the next full frame follows without a bubble;
  // iss_done stops a drained-but-not-yet-released bank from being fetched twice.
  assign ilen   = bank_len[ib];
  assign i_last = icnt == ilen - 1'b1;
  assign pop    = o_v & m_axis_llr_tready;
  assign issue  = bank_full[ib] & ~iss_done[ib] & ({1'b0, o_v} + {1'b0, s_v} + {1'b0, p_v} < {1'b1, pop});
  assign iss_set = {2{issue & i_last}} & (ib ? 2'b10 : 2'b01);
  assign o_fire_last = pop & o_q[EW-1];
  assign bf_clr = {2{o_fire_last}} & (rd_bank ? 2'b10 : 2'b01);
  assign p_ent  = {p_last, p_user, q};
  always_comb begin
    rd_nx = rd_st;
    if (o_fire_last) rd_nx = R_IDLE;
    else if (bank_full[rd_bank]) rd_nx = R_RUN;
  end
  always_ff @(posedge aclk or negedge rst_ni)
    if (!rst_ni) begin
      rd_st     <= R_IDLE;
      rd_bank   <= 1'b0;
      ib        <= 1'b0;
      icnt      <= '0;
      iss_done  <= '0;
      bank_full <= '0;
      p_v       <= 1'b0;
      p_user    <= 1'b0;
      p_last    <= 1'b0;
      o_v       <= 1'b0;
      s_v       <= 1'b0;
      o_q       <= '0;
      s_q       <= '0;
    end else begin
      rd_st     <= rd_nx;
      bank_full <= (bank_full | bf_set) & ~bf_clr;
      iss_done  <= (iss_done | iss_set) & ~bf_clr;
      if (o_fire_last) rd_bank <= ~rd_bank;
      if (issue) begin
        icnt <= i_last ? '0 : icnt + 1'b1;
        if (i_last) ib <= ~ib;
      end
      p_v    <= issue;
      p_user <= icnt == '0;
      p_last <= i_last;
      if (pop | ~o_v) begin
        o_v <= s_v | p_v;
        if (s_v | p_v) o_q <= s_v ? s_q : p_ent;
        s_v <= s_v & p_v;
        if (s_v & p_v) s_q <= p_ent;
      end else if (p_v) begin
        s_v <= 1'b1;
        s_q <= p_ent;
      end
    end
  assign m_axis_llr_tvalid = o_v;
  assign m_axis_llr_tdata  = o_q[DATA_WIDTH-1:0];
  assign m_axis_llr_tuser  = o_q[DATA_WIDTH];
  assign m_axis_llr_tlast  = o_q[EW-1];
  llr_pingpong_ram #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_ram (
    .aclk  (aclk),
    .we    (s_fire),
    .waddr ({wr_bank, cur_idx[AW-2:0]}),
    .wdata (s_axis_in_tdata),
    .raddr ({ib, icnt[AW-2:0]}),
    .rdata (q)
  );
endmodule

// File: tb/tb_llr_frame_scheduler.sv
// tb_llr_frame_scheduler: directed bench for llr_frame_scheduler with DEPTH_BUF=256.
`timescale 1ns/1ps
module tb_llr_frame_scheduler;
  logic aclk = 0, aresetn = 0;
  logic [15:0] blklen = 0, s_tdata = 0, m_tdata;
  logic s_tvalid = 0, s_tready, s_tlast = 0;
  logic m_tvalid, m_tready = 0, m_tuser, m_tlast, frm_err;
  logic [1:0] bank_full;
  int n_chk = 0, n_fail = 0, cyc = 0, pushed = 0, err_cnt = 0;
  int stall_viol = 0, stalls = 0, overlap = 0, timeouts = 0, rdy_mode = 0;
  int bf_cyc = 0, v_cyc = 0, w1 = 0, w2 = 0;
  logic [17:0] rx[$];
  int rx_c[$];
  logic stall_pend = 0;
  logic [17:0] stall_d = 0;

  llr_frame_scheduler #(.DATA_WIDTH(16), .DEPTH_BUF(256)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .blklen            (blklen),
    .s_axis_in_tdata   (s_tdata),
    .s_axis_in_tvalid  (s_tvalid),
    .s_axis_in_tready  (s_tready),
    .s_axis_in_tlast   (s_tlast),
    .m_axis_llr_tdata  (m_tdata),
    .m_axis_llr_tvalid (m_tvalid),
    .m_axis_llr_tready (m_tready),
    .m_axis_llr_tuser  (m_tuser),
    .m_axis_llr_tlast  (m_tlast),
    .bank_full         (bank_full),
    .frm_err           (frm_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  initial forever begin
    @(posedge aclk);
    #1 m_tready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(rdy_mode == 1);
  end

  always @(negedge aclk)
    if (!aresetn) stall_pend = 0;
    else begin
      if (stall_pend && (!m_tvalid || {m_tlast, m_tuser, m_tdata} != stall_d)) stall_viol++;
      stall_pend = m_tvalid && !m_tready;
      if (stall_pend) stalls++;
      stall_d = {m_tlast, m_tuser, m_tdata};
      if (m_tvalid && m_tready) begin
        rx.push_back({m_tlast, m_tuser, m_tdata});
        rx_c.push_back(cyc);
      end
      if (frm_err) err_cnt++;
      if ((dut.bf_set & dut.bf_clr) != 2'b00) overlap++;
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int t = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1;
    @(negedge aclk);
    while (!s_tready && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (!s_tready) timeouts++;
    else pushed++;
    @(posedge aclk);
    #1 s_tvalid = 0;
    s_tlast = 0;
  endtask

  task automatic push_frame(input logic [15:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) push(base + 16'(i), 1'(i == last_at));
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx.size() < n && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    if (rx.size() < n) timeouts++;
  endtask

  task automatic chk_frame(input string tag, input int off, input logic [15:0] base, input int len);
    for (int i = 0; i < len; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(rx[off+i]),
            {14'd0, 1'(i == len - 1), 1'(i == 0), base + 16'(i)});
  endtask

  task automatic clr_rx();
    rx.delete();
    rx_c.delete();
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_tready", 32'(s_tready), 0);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_bank_full", 32'(bank_full), 0);
    check("rst_frm_err", 32'(frm_err), 0);
    aresetn = 1;
    repeat (4) @(posedge aclk);
    #1;
    check("post_rst_s_tready", 32'(s_tready), 1);
    check("post_rst_m_tvalid", 32'(m_tvalid), 0);

    // single frame, latency from bank_full to first valid
    rdy_mode = 1;
    blklen = 8;
    clr_rx();
    fork
      push_frame(16'd1, 8, -1);
      begin
        while (!bank_full[0] && w1 < 200) begin
          @(negedge aclk);
          w1++;
        end
        bf_cyc = cyc;
        while (!m_tvalid && w2 < 200) begin
          @(negedge aclk);
          w2++;
        end
        v_cyc = cyc;
      end
    join
    wait_rx(8);
    repeat (2) @(posedge aclk);
    #1;
    chk_frame("t1", 0, 16'd1, 8);
    check("t1_latency", 32'(v_cyc - bf_cyc), 2);
    check("t1_bank_released", 32'(bank_full), 0);

    // both banks fill under backpressure, then drain
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    blklen = 4;
    clr_rx();
    pushed = 0;
    fork
      push_frame(16'd101, 12, -1);
    join_none
    repeat (30) @(posedge aclk);
    #1;
    check("t2_accepted", 32'(pushed), 8);
    check("t2_bank_full", 32'(bank_full), 3);
    check("t2_s_tready", 32'(s_tready), 0);
    rdy_mode = 1;
    wait_rx(12);
    chk_frame("t2a", 0, 16'd101, 4);
    chk_frame("t2b", 4, 16'd105, 4);
    chk_frame("t2c", 8, 16'd109, 4);
    check("t2_no_bubble", 32'(rx_c[7] - rx_c[0]), 7);

    // blklen=0 clamps to DEPTH_BUF
    repeat (4) @(posedge aclk);
    #1;
    blklen = 0;
    clr_rx();
    err_cnt = 0;
    push_frame(16'd0, 256, -1);
    blklen = 44;
    push_frame(16'd256, 44, -1);
    wait_rx(300);
    chk_frame("t3a", 0, 16'd0, 256);
    chk_frame("t3b", 256, 16'd256, 44);
    check("t3_frm_err", 32'(err_cnt), 1);

    // random output backpressure
    repeat (4) @(posedge aclk);
    #1;
    blklen = 16;
    clr_rx();
    stalls = 0;
    stall_viol = 0;
    rdy_mode = 2;
    push_frame(16'd500, 16, -1);
    push_frame(16'd516, 16, -1);
    wait_rx(32);
    chk_frame("t4a", 0, 16'd500, 16);
    chk_frame("t4b", 16, 16'd516, 16);
    check("t4_stable_stall", 32'(stall_viol), 0);
    check("t4_stalls_seen", 32'(stalls > 0), 1);

    // upstream tlast on beat 6 of a 10-beat frame
    rdy_mode = 1;
    repeat (4) @(posedge aclk);
    #1;
    blklen = 10;
    clr_rx();
    err_cnt = 0;
`ifdef TLAST_CHECK_EN
    push_frame(16'd700, 6, 5);
    wait_rx(6);
    repeat (10) @(posedge aclk);
    #1;
    chk_frame("t5", 0, 16'd700, 6);
    check("t5_beats", 32'(rx.size()), 6);
    check("t5_frm_err", 32'(err_cnt), 1);
`else
    push_frame(16'd700, 10, 5);
    wait_rx(10);
    repeat (10) @(posedge aclk);
    #1;
    chk_frame("t5", 0, 16'd700, 10);
    check("t5_beats", 32'(rx.size()), 10);
    check("t5_frm_err", 32'(err_cnt), 0);
`endif

    // reset in the middle of an output frame
    blklen = 8;
    clr_rx();
    push_frame(16'd800, 8, -1);
    wait_rx(3);
    aresetn = 0;
    #1;
    check("t6_rst_tvalid", 32'(m_tvalid), 0);
    check("t6_rst_tuser_tlast", {30'd0, m_tuser, m_tlast}, 0);
    check("t6_rst_tdata", 32'(m_tdata), 0);
    check("t6_rst_bank_full", 32'(bank_full), 0);
    check("t6_rst_s_tready", 32'(s_tready), 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1;
    repeat (4) @(posedge aclk);
    #1;
    check("t6_partial_dropped", 32'(rx.size()), 3);
    blklen = 2;
    clr_rx();
    push_frame(16'd900, 2, -1);
    wait_rx(2);
    repeat (20) @(posedge aclk);
    #1;
    chk_frame("t6", 0, 16'd900, 2);
    check("t6_beats", 32'(rx.size()), 2);

    check("timeouts", 32'(timeouts), 0);
    check("set_clr_same_bank", 32'(overlap), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
